// File: rtl/pipefft_twid_loader.sv
// Packs pairs of 32-bit stream words (low first) into 64-bit twiddle RAM writes, with a load checksum.
// Latency: a write appears the cycle after its high-word handshake. Backpressure: IN_READY depends only on state.
module pipefft_twid_loader #(
    parameter int ADDR_W = 10,
    parameter int WORD_W = 32
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  START,
    input  logic [ADDR_W:0]       LEN,
    input  logic                  ABORT,
    input  logic [WORD_W-1:0]     IN_DATA,
    input  logic                  IN_VALID,
    output logic                  IN_READY,
    output logic [ADDR_W-1:0]     WADDR,
    output logic [2*WORD_W-1:0]   DI,
    output logic                  WRB,
    output logic                  BUSY,
    output logic                  DONE,
    output logic [2*WORD_W-1:0]   CHECKSUM
);

    typedef enum logic [1:0] {S_IDLE, S_LO, S_HI, S_FIN} state_t;

    typedef struct packed {
        logic [WORD_W-1:0] hi;
        logic [WORD_W-1:0] lo;
    } entry_t;

    localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] ONE   = {{ADDR_W{1'b0}}, 1'b1};

    state_t            state, state_nxt;
    logic [ADDR_W:0]   len_q;
    logic [ADDR_W:0]   cnt;
    logic [ADDR_W:0]   len_sat;
    logic [WORD_W-1:0] lo_reg;
    entry_t            entry;
    logic              hs;
    logic              last;
    logic              start_ok;

    // ABORT suppresses any handshake in its own cycle, so an aborted HI never writes.
    assign hs       = IN_VALID && IN_READY && !ABORT;
    assign entry    = '{hi: IN_DATA, lo: lo_reg};
    assign last     = ((cnt + ONE) == len_q);
    assign len_sat  = (LEN > DEPTH) ? DEPTH : LEN;
    assign start_ok = (state == S_IDLE) && START && !ABORT;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: begin
                if (start_ok) begin
                    state_nxt = (len_sat == '0) ? S_FIN : S_LO;
                end
            end
            S_LO: begin
                if (ABORT) begin
                    state_nxt = S_IDLE;
                end else if (hs) begin
                    state_nxt = S_HI;
                end
            end
            S_HI: begin
                if (ABORT) begin
                    state_nxt = S_IDLE;
                end else if (hs) begin
                    state_nxt = last ? S_FIN : S_LO;
                end
            end
            S_FIN: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        IN_READY = 1'b0;
        BUSY     = 1'b0;
        DONE     = 1'b0;
        unique case (state)
            S_LO, S_HI: begin
                IN_READY = 1'b1;
                BUSY     = 1'b1;
            end
            S_FIN:   DONE = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            len_q    <= '0;
            cnt      <= '0;
            lo_reg   <= '0;
            WADDR    <= '0;
            DI       <= '0;
            WRB      <= 1'b0;
            CHECKSUM <= '0;
        end else begin
            WRB <= 1'b0;
            if (start_ok) begin
                len_q    <= len_sat;
                cnt      <= '0;
                CHECKSUM <= '0;
            end
            if (state == S_LO && hs) begin
                lo_reg <= IN_DATA;
            end
            // cnt stays within the table because len_q saturates at DEPTH.
            if (state == S_HI && hs) begin
                WRB      <= 1'b1;
                WADDR    <= cnt[ADDR_W-1:0];
                DI       <= entry;
                CHECKSUM <= CHECKSUM ^ entry;
                cnt      <= cnt + ONE;
            end
        end
    end

endmodule

// File: tb/tb_pipefft_twid_loader.sv
// Randomized bench for pipefft_twid_loader: word-level reference model, per-cycle compare, RAM loopback.
module tb_pipefft_twid_loader;
    localparam int AW    = 10;
    localparam int WW    = 32;
    localparam int DEPTH = 1024;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            start = 1'b0;
    logic [AW:0]     len = '0;
    logic            abort = 1'b0;
    logic [WW-1:0]   in_data = '0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [AW-1:0]   waddr;
    logic [2*WW-1:0] di;
    logic            wrb;
    logic            busy;
    logic            done;
    logic [2*WW-1:0] checksum;

    always #5 clk = ~clk;

    pipefft_twid_loader #(.ADDR_W(AW), .WORD_W(WW)) dut (
        .CLK(clk), .RST(rst), .START(start), .LEN(len), .ABORT(abort),
        .IN_DATA(in_data), .IN_VALID(in_valid), .IN_READY(in_ready),
        .WADDR(waddr), .DI(di), .WRB(wrb), .BUSY(busy), .DONE(done), .CHECKSUM(checksum)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: tracks how many words of the current load were accepted.
    logic        m_busy = 1'b0;
    logic        m_wrb = 1'b0;
    logic        m_done = 1'b0;
    logic [63:0] m_cks = '0;
    logic [63:0] m_di = '0;
    logic [31:0] m_lo = '0;
    int          m_waddr = 0;
    int          m_len = 0;
    int          m_words = 0;

    initial forever begin
        logic fin_prev;
        @(posedge clk);
        fin_prev = m_done;
        cyc++;
        m_wrb  = 1'b0;
        m_done = 1'b0;
        if (rst) begin
            m_busy = 1'b0;
            m_cks  = '0;
        end else if (m_busy) begin
            if (abort) begin
                m_busy = 1'b0;
            end else if (in_valid) begin
                if (m_words % 2 == 0) begin
                    m_lo = in_data;
                end else begin
                    m_wrb   = 1'b1;
                    m_waddr = m_words / 2;
                    m_di    = {in_data, m_lo};
                    m_cks   = m_cks ^ m_di;
                    if (m_waddr + 1 == m_len) begin
                        m_busy = 1'b0;
                        m_done = 1'b1;
                    end
                end
                m_words++;
            end
        end else if (!fin_prev && start && !abort) begin
            m_len   = (int'(len) > DEPTH) ? DEPTH : int'(len);
            m_cks   = '0;
            m_words = 0;
            if (m_len == 0) m_done = 1'b1;
            else            m_busy = 1'b1;
        end
    end

    int   n_wrb = 0;
    int   n_done = 0;
    int   last_waddr = -1;
    int   done_cyc = -1;
    logic cmp_en = 1'b0;

    initial forever begin
        @(negedge clk);
        if (cmp_en) begin
            chk("in_ready", {63'b0, in_ready}, {63'b0, m_busy});
            chk("busy", {63'b0, busy}, {63'b0, m_busy});
            chk("done", {63'b0, done}, {63'b0, m_done});
            chk("wrb", {63'b0, wrb}, {63'b0, m_wrb});
            chk("checksum", checksum, m_cks);
            if (m_wrb) begin
                chk("waddr", 64'(waddr), 64'(m_waddr));
                chk("di", di, m_di);
            end
        end
        if (wrb === 1'b1) begin
            n_wrb++;
            last_waddr = int'(waddr);
        end
        if (done === 1'b1) begin
            n_done++;
            done_cyc = cyc;
        end
    end

    // Writer-side RAM model with its read port (RADDR/RDB/DO).
    logic [63:0]   ram [0:DEPTH-1];
    logic [AW-1:0] raddr = '0;
    logic          rdb = 1'b0;
    logic [63:0]   ram_do;

    always @(posedge clk) begin
        if (wrb) ram[waddr] <= di;
        if (rdb) ram_do <= ram[raddr];
    end

    logic [31:0] wbuf [0:2*DEPTH-1];

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic fill(input int mode);
        for (int i = 0; i < 2 * DEPTH; i++) begin
            int  k;
            int  v;
            real ang;
            k = i / 2;
            case (mode)
                0: wbuf[i] = (i % 2 == 1) ? ~k : k;
                1: wbuf[i] = $urandom;
                default: begin
                    ang = 6.283185307179586 * k / 1024.0;
                    v = $rtoi(((i % 2 == 1) ? $sin(ang) : $cos(ang)) * 32767.0);
                    wbuf[i] = v;
                end
            endcase
        end
    endtask

    task automatic do_start(input int l, output int t0);
        t0    = cyc;
        start = 1'b1;
        len   = l[AW:0];
        step();
        start = 1'b0;
        len   = $urandom_range(0, 2047);
    endtask

    task automatic send_words(input int from, input int to, input int duty);
        int i;
        int guard;
        i = from;
        guard = 0;
        while (i < to && guard < 20000) begin
            in_data  = wbuf[i];
            in_valid = ($urandom_range(0, 99) < duty);
            if (in_valid && in_ready) i++;
            step();
            guard++;
        end
        in_valid = 1'b0;
        if (i < to) chk("send_timeout", 64'(i), 64'(to));
    endtask

    initial begin
        int t0, w0, d0, l, n;

        step();
        cmp_en = 1'b1;
        step();
        chk("rst_in_ready", {63'b0, in_ready}, 64'd0);
        chk("rst_waddr", 64'(waddr), 64'd0);
        chk("rst_di", di, 64'd0);
        chk("rst_wrb", {63'b0, wrb}, 64'd0);
        chk("rst_busy", {63'b0, busy}, 64'd0);
        chk("rst_done", {63'b0, done}, 64'd0);
        chk("rst_checksum", checksum, 64'd0);
        rst = 1'b0;
        step();

        // LEN = 0: DONE one cycle after START, no write
        w0 = n_wrb;
        do_start(0, t0);
        chk("len0_done_lat", 64'(done_cyc - t0), 64'd1);
        chk("len0_writes", 64'(n_wrb - w0), 64'd0);
        chk("len0_checksum", checksum, 64'd0);
        step(); step();

        // Full load, continuous valid, words k / ~k
        fill(0);
        w0 = n_wrb;
        do_start(1024, t0);
        send_words(0, 2048, 100);
        chk("full_done_lat", 64'(done_cyc - t0), 64'd2049);
        chk("full_writes", 64'(n_wrb - w0), 64'd1024);
        chk("full_last_waddr", 64'(last_waddr), 64'd1023);
        chk("full_checksum", checksum, 64'd0);
        step(); step();

        // Backpressure: LEN = 4 at 30% valid duty
        fill(1);
        w0 = n_wrb; d0 = n_done;
        do_start(4, t0);
        send_words(0, 8, 30);
        step(); step();
        chk("bp_writes", 64'(n_wrb - w0), 64'd4);
        chk("bp_dones", 64'(n_done - d0), 64'd1);

        // Saturating length
        fill(1);
        w0 = n_wrb;
        do_start(2047, t0);
        send_words(0, 2048, 100);
        step(); step();
        chk("sat_writes", 64'(n_wrb - w0), 64'd1024);
        chk("sat_last_waddr", 64'(last_waddr), 64'd1023);

        // Random short loads
        for (int r = 0; r < 4; r++) begin
            fill(1);
            l = $urandom_range(1, 40);
            w0 = n_wrb;
            do_start(l, t0);
            send_words(0, 2 * l, $urandom_range(40, 100));
            step(); step();
            chk("rand_writes", 64'(n_wrb - w0), 64'(l));
        end

        // ABORT after 3 entries plus one low word
        fill(0);
        w0 = n_wrb; d0 = n_done;
        do_start(8, t0);
        send_words(0, 7, 100);
        abort = 1'b1;
        step();
        abort = 1'b0;
        step(); step();
        chk("abort_writes", 64'(n_wrb - w0), 64'd3);
        chk("abort_dones", 64'(n_done - d0), 64'd0);
        chk("abort_busy", {63'b0, busy}, 64'd0);
        w0 = n_wrb;
        do_start(2, t0);
        send_words(0, 4, 100);
        step(); step();
        chk("post_abort_writes", 64'(n_wrb - w0), 64'd2);
        chk("post_abort_last", 64'(last_waddr), 64'd1);
        chk("post_abort_cks", checksum, 64'h0000_0001_0000_0001);

        // START during a load is ignored and LEN is not resampled
        w0 = n_wrb; d0 = n_done;
        do_start(6, t0);
        send_words(0, 4, 100);
        start = 1'b1;
        len   = 11'd2;
        step();
        start = 1'b0;
        send_words(4, 12, 100);
        step(); step();
        chk("restart_writes", 64'(n_wrb - w0), 64'd6);
        chk("restart_dones", 64'(n_done - d0), 64'd1);

        // RST in the cycle of a high-word handshake
        w0 = n_wrb;
        do_start(4, t0);
        send_words(0, 3, 100);
        in_data  = wbuf[3];
        in_valid = 1'b1;
        rst      = 1'b1;
        step();
        chk("rsths_wrb", {63'b0, wrb}, 64'd0);
        chk("rsths_waddr", 64'(waddr), 64'd0);
        chk("rsths_di", di, 64'd0);
        chk("rsths_busy", {63'b0, busy}, 64'd0);
        chk("rsths_ready", {63'b0, in_ready}, 64'd0);
        chk("rsths_checksum", checksum, 64'd0);
        chk("rsths_writes", 64'(n_wrb - w0), 64'd1);
        rst = 1'b0;
        in_valid = 1'b0;
        step();
        w0 = n_wrb;
        do_start(2, t0);
        send_words(0, 4, 100);
        step(); step();
        chk("rsths_reload_last", 64'(last_waddr), 64'd1);
        chk("rsths_reload_writes", 64'(n_wrb - w0), 64'd2);

        // Loopback: sine/cosine table, read every address back
        fill(2);
        do_start(1024, t0);
        send_words(0, 2048, 100);
        step(); step();
        for (int a = 0; a < DEPTH; a++) begin
            raddr = a[AW-1:0];
            rdb   = 1'b1;
            step();
            chk("loopback_do", ram_do, {wbuf[2 * a + 1], wbuf[2 * a]});
        end
        rdb = 1'b0;
        n = n_done;
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
